// File: rtl/sha_uart_pkg.sv
// Shared types and constants for streaming a hash digest out through a byte UART.
package sha_uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_IDLE = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int DEFAULT_DIGEST_BITS = 256;
  localparam int DIGEST_BYTES        = DEFAULT_DIGEST_BITS / 8;
  localparam int HEX_CHARS           = 2 * DIGEST_BYTES;

  // Number of UART characters one digest produces in the chosen output mode.
  function automatic int chars_per_digest(input int digest_bits, input int hex_ascii);
    return (hex_ascii != 0) ? (digest_bits / 4) : (digest_bits / 8);
  endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational nibble to lowercase ASCII hex character ('0'-'9', 'a'-'f').
module hex_nibble_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
    else                ascii = 8'h57 + {4'h0, nibble};
  end

endmodule

// File: rtl/sha_digest_to_uart.sv
// Serialises a captured digest to a UART transmitter, one character per frame,
// as raw bytes or as lowercase ASCII hex, MSB byte first.
module sha_digest_to_uart
  import sha_uart_pkg::*;
#(
  parameter int DIGEST_BITS = DEFAULT_DIGEST_BITS,
  parameter int HEX_ASCII   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DIGEST_BITS-1:0] digest,
  input  logic                   digest_valid,
  output logic                   digest_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_busy,
  output logic                   done,
  output logic [2:0]             state_dbg
);

  localparam int N_CHARS = chars_per_digest(DIGEST_BITS, HEX_ASCII);
  localparam int CW      = $clog2(2 * (DIGEST_BITS / 8) + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_CHARS - 1);

  state_t                 state, state_nx;
  logic [DIGEST_BITS-1:0] shift_q;
  logic [CW-1:0]          cnt_q;
  logic                   capture, advance, last_char;
  logic [3:0]             nibble;
  logic [7:0]             nib_ascii, cur_char;

  // Handshake: a digest transfers on any rising edge where digest_valid and
  // digest_ready are both high; digest_ready is high only while IDLE, so a
  // digest offered mid-stream is neither captured nor allowed to disturb it.
  assign capture   = (state == IDLE) && digest_valid;
  assign advance   = (state == WAIT_IDLE) && !tx_busy;
  assign last_char = (cnt_q == LAST_IDX);

  // Even counts select the high nibble of the current byte, odd counts the low.
  assign nibble   = cnt_q[0] ? shift_q[DIGEST_BITS-5 -: 4] : shift_q[DIGEST_BITS-1 -: 4];
  assign cur_char = (HEX_ASCII != 0) ? nib_ascii : shift_q[DIGEST_BITS-1 -: 8];

  hex_nibble_to_ascii u_hex (
    .nibble (nibble),
    .ascii  (nib_ascii)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (digest_valid) state_nx = START;
      START:     state_nx = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_nx = WAIT_IDLE;
      WAIT_IDLE: if (!tx_busy) state_nx = last_char ? DONE : START;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // In hex mode the byte only leaves the register once both nibbles are sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (capture) begin
      shift_q <= digest;
      cnt_q   <= '0;
    end else if (advance) begin
      cnt_q <= cnt_q + CW'(1);
      if ((HEX_ASCII == 0) || cnt_q[0]) shift_q <= shift_q << 8;
    end else if (state == DONE) begin
      cnt_q <= '0;
    end
  end

  assign digest_ready = (state == IDLE);
  assign tx_start     = (state == START);
  assign done         = (state == DONE);
  assign tx_data      = ((state == START) || (state == WAIT_BUSY) || (state == WAIT_IDLE))
                        ? cur_char : 8'h00;
  assign state_dbg    = state;

endmodule

// File: tb/tb_sha_digest_to_uart.sv
// Bench for sha_digest_to_uart: a raw-mode and a hex-mode instance, each fed by a
// UART model, with every character checked against a reference stream built from the digest.
module tb_sha_digest_to_uart;
  import sha_uart_pkg::*;

  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0 = raw instance, index 1 = hex instance
  logic [255:0] digest;
  logic         dv[2];
  logic         ready[2];
  logic [7:0]   txd[2];
  logic         txs[2];
  logic         busy[2];
  logic         dn[2];
  logic [2:0]   sd[2];

  sha_digest_to_uart #(.DIGEST_BITS(256), .HEX_ASCII(0)) u_raw (
    .clk(clk), .rst(rst), .digest(digest), .digest_valid(dv[0]), .digest_ready(ready[0]),
    .tx_data(txd[0]), .tx_start(txs[0]), .tx_busy(busy[0]), .done(dn[0]), .state_dbg(sd[0])
  );

  sha_digest_to_uart #(.DIGEST_BITS(256), .HEX_ASCII(1)) u_hex (
    .clk(clk), .rst(rst), .digest(digest), .digest_valid(dv[1]), .digest_ready(ready[1]),
    .tx_data(txd[1]), .tx_start(txs[1]), .tx_busy(busy[1]), .done(dn[1]), .state_dbg(sd[1])
  );

  // UART model: a frame keeps tx_busy high for frame_len cycles after tx_start;
  // force_busy models a transmitter still busy with traffic from elsewhere.
  int   frame_len = 10;
  logic force_busy = 1'b0;
  int   busy_cnt[2] = '{0, 0};
  int   cyc = 0;
  int   done_cnt = 0;
  logic [7:0] rx_q[$];
  int         start_cyc_q[$];

  assign busy[0] = force_busy || (busy_cnt[0] != 0);
  assign busy[1] = force_busy || (busy_cnt[1] != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (txs[g] === 1'b1) begin
        rx_q.push_back(txd[g]);
        start_cyc_q.push_back(cyc);
        busy_cnt[g] <= frame_len;
      end else if (busy_cnt[g] != 0) begin
        busy_cnt[g] <= busy_cnt[g] - 1;
      end
      if (dn[g] === 1'b1) done_cnt <= done_cnt + 1;
    end
  end

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference stream: bytes MSB first, or two lowercase hex characters per byte.
  function automatic void build_exp(input int m, input logic [255:0] d);
    string      hx;
    logic [7:0] b;
    hx = "0123456789abcdef";
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      b = d[255 - 8*i -: 8];
      if (m == 0) exp_q.push_back(b);
      else begin
        exp_q.push_back(hx[int'(b[7:4])]);
        exp_q.push_back(hx[int'(b[3:0])]);
      end
    end
  endfunction

  function automatic logic [255:0] rand_digest();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // driver tasks
  task automatic start_tx(input int m, input logic [255:0] d, input int len,
                          output int base, output int bdone);
    frame_len = len;
    base  = rx_q.size();
    bdone = done_cnt;
    @(negedge clk);
    chk("ready_before_capture", ready[m], 1);
    digest = d;
    dv[m]  = 1'b1;
    @(negedge clk);
    dv[m] = 1'b0;
    chk("ready_after_capture", ready[m], 0);
    chk("tx_start_after_capture", txs[m], 1);
  endtask

  task automatic wait_chars(input int base, input int n);
    int k;
    k = 0;
    while ((rx_q.size() - base) < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("chars_reached", rx_q.size() - base, n);
  endtask

  task automatic finish_tx(input int m, input logic [255:0] d, input int len, input int base,
                           input int bdone, input int gap_from, input string tag);
    int n, k, got;
    build_exp(m, d);
    n = exp_q.size();
    k = 0;
    while (dn[m] !== 1'b1 && k < n * (len + 4) + 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, dn[m], 1);
    chk({tag, "_ready_in_done"}, ready[m], 0);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, dn[m], 0);
    chk({tag, "_ready_after_done"}, ready[m], 1);
    chk({tag, "_done_count"}, done_cnt - bdone, 1);
    got = rx_q.size() - base;
    chk({tag, "_char_count"}, got, n);
    for (int i = 0; i < n && i < got; i++)
      chk($sformatf("%s_char%0d", tag, i), rx_q[base + i], exp_q[i]);
    for (int i = gap_from; i < n && i < got; i++)
      chk($sformatf("%s_gap%0d", tag, i),
          start_cyc_q[base + i] - start_cyc_q[base + i - 1], len + 2);
  endtask

  initial begin
    int base, bdone, m, len;
    logic [255:0] d;

    rst = 1'b1; dv[0] = 1'b0; dv[1] = 1'b0; digest = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_tx_start", txs[g], 0);
      chk("reset_done", dn[g], 0);
      chk("reset_tx_data", txd[g], 8'h00);
      chk("reset_state", sd[g], IDLE);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset_raw", ready[0], 1);
    chk("ready_after_reset_hex", ready[1], 1);

    // SHA-256("abc") in both output modes, 10-cycle frames
    start_tx(0, ABC_DIGEST, 10, base, bdone);
    finish_tx(0, ABC_DIGEST, 10, base, bdone, 1, "abc_raw");
    start_tx(1, ABC_DIGEST, 10, base, bdone);
    finish_tx(1, ABC_DIGEST, 10, base, bdone, 1, "abc_hex");

    // random digests and frame lengths in both modes
    for (int t = 0; t < 4; t++) begin
      m   = t % 2;
      len = $urandom_range(1, 6);
      d   = rand_digest();
      start_tx(m, d, len, base, bdone);
      finish_tx(m, d, len, base, bdone, 1, $sformatf("rand%0d", t));
    end

    // a second digest offered at byte 5 must be ignored
    d = rand_digest();
    start_tx(0, d, 4, base, bdone);
    wait_chars(base, 6);
    for (int i = 0; i < 4; i++) begin
      digest = ~d;
      dv[0]  = 1'b1;
      @(negedge clk);
      chk("ready_low_midstream", ready[0], 0);
    end
    dv[0] = 1'b0;
    finish_tx(0, d, 4, base, bdone, 1, "ignore");

    // transmitter already busy at START, then 1-cycle frames: 3-cycle spacing
    force_busy = 1'b1;
    d = rand_digest();
    start_tx(0, d, 1, base, bdone);
    repeat (6) @(negedge clk);
    chk("single_issue_while_busy", rx_q.size() - base, 1);
    force_busy = 1'b0;
    finish_tx(0, d, 1, base, bdone, 2, "prebusy");

    // reset during WAIT_IDLE of byte 10 aborts; a new digest restarts at byte 0
    d = rand_digest();
    start_tx(0, d, 10, base, bdone);
    wait_chars(base, 11);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx_start", txs[0], 0);
    chk("abort_done", dn[0], 0);
    chk("abort_ready", ready[0], 1);
    chk("abort_tx_data", txd[0], 8'h00);
    rst = 1'b0;
    base = rx_q.size();
    bdone = done_cnt;
    repeat (20) @(negedge clk);
    chk("no_tx_after_abort", rx_q.size() - base, 0);
    chk("no_done_after_abort", done_cnt - bdone, 0);
    d = rand_digest();
    start_tx(0, d, 3, base, bdone);
    finish_tx(0, d, 3, base, bdone, 1, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
